// File: rtl/chall_pkg.sv
// Shared types, defaults and byte-rotate helpers for the challenge cipher.
// The checker software and the reference models use the same rotate helpers.
package chall_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t       DEFAULT_KEY = 8'hA5;
    localparam int unsigned DEFAULT_ROT = 3;

    // Rotate left. {x,x} shifted left leaves the rotated byte in the upper half.
    function automatic byte_t rotl8(input byte_t x, input logic [2:0] amt);
        logic [15:0] dbl;
        dbl = {x, x} << amt;
        return dbl[15:8];
    endfunction

    // Rotate right. {x,x} shifted right leaves the rotated byte in the lower half.
    function automatic byte_t rotr8(input byte_t x, input logic [2:0] amt);
        logic [15:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[7:0];
    endfunction

endpackage

// File: rtl/chall_xform.sv
// Combinational whitening-then-rotate datapath: dout = rotl(din ^ KEY, ROT).
// Pure function of din, no state. X on din propagates to dout.
module chall_xform
    import chall_pkg::*;
#(
    parameter byte_t       KEY = DEFAULT_KEY,
    parameter int unsigned ROT = DEFAULT_ROT
) (
    input  byte_t din,
    output byte_t dout
);

    // Only the low three bits of the rotate amount are meaningful for a byte.
    localparam logic [2:0] ROT_AMT = 3'(ROT);

    byte_t whitened;

    // Whiten with the key, then rotate left by the fixed amount.
    always_comb begin
        whitened = din ^ KEY;
        dout     = rotl8(whitened, ROT_AMT);
    end

endmodule

// File: rtl/chall_byte_cipher.sv
// Streaming single-byte cipher: one byte in per clock, the transformed byte
// appears registered one cycle later. Output comes only from the flop; the
// asynchronous active-low reset clears it immediately and drops any byte in flight.
module chall_byte_cipher
    import chall_pkg::*;
#(
    parameter byte_t       KEY = DEFAULT_KEY,
    parameter int unsigned ROT = DEFAULT_ROT
) (
    input  logic  clk,
    input  logic  rst,
    input  byte_t inp,
    output byte_t res
);

    localparam logic [2:0] ROT_AMT = 3'(ROT);

    byte_t res_d;
    byte_t res_q;

    chall_xform #(
        .KEY (KEY),
        .ROT (ROT)
    ) u_xform (
        .din  (inp),
        .dout (res_d)
    );

    // Output register: captures the transformed byte every edge, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= 8'h00;
        end else begin
            res_q <= res_d;
        end
    end

    assign res = res_q;

    // Reset must hold the output at zero.
    a_reset_zero : assert property (@(posedge clk) !rst |-> (res_q == 8'h00));

    // Decrypting the output must recover the byte sampled one edge earlier,
    // which also shows the transform is invertible (a bijection).
    a_bijection : assert property (@(posedge clk) disable iff (!rst)
        ($past(rst) && !$isunknown($past(inp))) |->
            ((rotr8(res_q, ROT_AMT) ^ KEY) == $past(inp)));

endmodule

// File: tb/tb_chall_byte_cipher.sv
// Directed bench for chall_byte_cipher: default instance plus two parameter
// variants, all fed the same byte stream. Expected bytes are queued when a
// byte is driven and popped after the capturing edge.
module tb_chall_byte_cipher;

    logic       clk;
    logic       rst;
    logic [7:0] inp;
    logic [7:0] res_def;
    logic [7:0] res_id;
    logic [7:0] res_ff7;

    int n_cmp;
    int n_err;

    logic [7:0] q_def[$];
    logic [7:0] q_id[$];
    logic [7:0] q_ff7[$];

    bit seen[256];

    chall_byte_cipher u_def (
        .clk (clk),
        .rst (rst),
        .inp (inp),
        .res (res_def)
    );

    chall_byte_cipher #(.KEY(8'h00), .ROT(0)) u_id (
        .clk (clk),
        .rst (rst),
        .inp (inp),
        .res (res_id)
    );

    chall_byte_cipher #(.KEY(8'hFF), .ROT(7)) u_ff7 (
        .clk (clk),
        .rst (rst),
        .inp (inp),
        .res (res_ff7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent bit-by-bit reference: bit i of the whitened byte moves to bit (i+rot)%8.
    function automatic logic [7:0] model(input logic [7:0] b, input logic [7:0] key, input int rot);
        logic [7:0] x;
        logic [7:0] y;
        x = b ^ key;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            y[(i + rot) % 8] = x[i];
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte at the falling edge, queue expectations, then check after the capture edge.
    task automatic step(input logic [7:0] b, input string tag);
        logic [7:0] e;
        @(negedge clk);
        inp = b;
        q_def.push_back(model(b, 8'hA5, 3));
        q_id.push_back(model(b, 8'h00, 0));
        q_ff7.push_back(model(b, 8'hFF, 7));
        @(posedge clk);
        #1;
        e = q_def.pop_front();
        check({tag, "/def"}, res_def, e);
        e = q_id.pop_front();
        check({tag, "/id"}, res_id, e);
        e = q_ff7.pop_front();
        check({tag, "/ff7"}, res_ff7, e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/def"}, res_def, 8'h00);
        check({tag, "/id"}, res_id, 8'h00);
        check({tag, "/ff7"}, res_ff7, 8'h00);
    endtask

    initial begin
        int distinct;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        inp   = 8'hFF;

        // Reset held with a busy input: outputs stay zero across edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("reset_hold");
            @(negedge clk);
            inp = ~inp;
        end

        // Release reset; the very first edge captures normally.
        @(negedge clk);
        rst = 1'b1;
        step(8'h00, "first_after_reset");
        check("first_after_reset_const", res_def, 8'h2D);

        // Single vectors and back-to-back streaming.
        step(8'h41, "vec_41");
        check("vec_41_const", res_def, 8'h27);
        step(8'hA5, "vec_a5");
        check("vec_a5_const", res_def, 8'h00);
        step(8'h00, "stream0");
        step(8'h41, "stream1");
        step(8'hA5, "stream2");

        // ROT=7, KEY=FF corner.
        step(8'h01, "ff7_01");
        check("ff7_01_const", res_ff7, 8'h7F);

        // Exhaustive sweep with distinctness tracking on the default instance.
        for (int v = 0; v < 256; v++) begin
            step(8'(v), "sweep");
            seen[res_def] = 1'b1;
        end
        distinct = 0;
        for (int v = 0; v < 256; v++) begin
            if (seen[v]) distinct++;
        end
        check("distinct_outputs", 8'(distinct - 1), 8'hFF);

        // Asynchronous reset between edges while output is 27.
        step(8'h41, "pre_async");
        check("pre_async_const", res_def, 8'h27);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("async_reset_edge");
        @(negedge clk);
        rst = 1'b1;
        step(8'h3C, "resume");
        step(8'h41, "resume2");
        check("resume2_const", res_def, 8'h27);

        if (q_def.size() != 0 || q_id.size() != 0 || q_ff7.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", q_def.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
